// File: rtl/add_pipe.sv
// Pipelined WIDTH-bit adder/subtractor: one CHUNK-bit slice per stage, carry rippling
// stage to stage through registers, valid/ready handshake with a global stall.
module add_pipe #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] x,
    output logic             co,
    output logic             ovf
);
    localparam int N = (CHUNK > 0) ? WIDTH / CHUNK : 1;

    if (CHUNK < 1 || WIDTH < CHUNK || (WIDTH % CHUNK) != 0) begin : g_param_check
        $error("add_pipe: WIDTH (%0d) must be a positive multiple of CHUNK (%0d)", WIDTH, CHUNK);
    end

    // Stage k holds sum chunks 0..k, the carry out of chunk k, and the operands:
    // upper chunks still to be summed, MSBs kept for the overflow test.
    logic [N-1:0]            s_valid;
    logic [N-1:0]            s_carry;
    logic [N-1:0][WIDTH-1:0] s_sum;
    logic [N-1:0][WIDTH-1:0] s_a;
    logic [N-1:0][WIDTH-1:0] s_b;

    logic [N-1:0]            src_valid;
    logic [N-1:0]            src_carry;
    logic [N-1:0][WIDTH-1:0] src_sum;
    logic [N-1:0][WIDTH-1:0] src_a;
    logic [N-1:0][WIDTH-1:0] src_b;

    logic [N-1:0]            nxt_carry;
    logic [N-1:0][WIDTH-1:0] nxt_sum;
    logic                    stall;

    // Stage 0 sees the ports (subtract folded into b' and c0); stage k sees stage k-1.
    always_comb begin
        // NOTE: every combinational output gets a full default first so no path can
        // leave bits unassigned and infer a latch.
        src_valid = '0;
        src_carry = '0;
        src_sum   = '0;
        src_a     = '0;
        src_b     = '0;

        src_valid[0] = in_valid;
        src_a[0]     = a;
        src_b[0]     = sub ? ~b : b;
        src_carry[0] = sub ? ~ci : ci;
        for (int k = 1; k < N; k++) begin
            src_valid[k] = s_valid[k-1];
            src_carry[k] = s_carry[k-1];
            src_sum[k]   = s_sum[k-1];
            src_a[k]     = s_a[k-1];
            src_b[k]     = s_b[k-1];
        end
    end

    always_comb begin
        logic [CHUNK:0] part;
        part      = '0;
        nxt_sum   = '0;
        nxt_carry = '0;
        for (int k = 0; k < N; k++) begin
            part = {1'b0, src_a[k][k*CHUNK +: CHUNK]}
                 + {1'b0, src_b[k][k*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, src_carry[k]};
            nxt_sum[k]                    = src_sum[k];
            nxt_sum[k][k*CHUNK +: CHUNK]  = part[CHUNK-1:0];
            nxt_carry[k]                  = part[CHUNK];
        end
    end

    // NOTE: the stage registers are a handful of flops rather than a memory array, and
    // the outputs must read zero out of reset, so all of them are reset, not just valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_valid <= '0;
            s_carry <= '0;
            s_sum   <= '0;
            s_a     <= '0;
            s_b     <= '0;
        end else if (!stall) begin
            // NOTE: non-blocking so every stage advances from the pre-edge values.
            s_valid <= src_valid;
            for (int k = 0; k < N; k++) begin
                // Operands are sampled only on an accepting edge; stall is already 0 here.
                if (k != 0 || in_valid) begin
                    s_sum[k]   <= nxt_sum[k];
                    s_carry[k] <= nxt_carry[k];
                    s_a[k]     <= src_a[k];
                    s_b[k]     <= src_b[k];
                end
            end
        end
    end

    assign out_valid = s_valid[N-1];
    assign stall     = out_valid && !out_ready;
    assign in_ready  = !stall;
    assign x         = s_sum[N-1];
    assign co        = s_carry[N-1];
    assign ovf       = (s_a[N-1][WIDTH-1] == s_b[N-1][WIDTH-1]) &&
                       (x[WIDTH-1] != s_a[N-1][WIDTH-1]);

    // Only the MSBs of the last stage's operands are consumed.
    logic unused_operand_bits;
    assign unused_operand_bits = ^{s_a[N-1], s_b[N-1]};

endmodule

// File: tb/tb_add_pipe.sv
// Directed-vector and scoreboard bench for add_pipe at 8/4 (N=2), 8/8 (N=1) and 32/8 (N=4).
module tb_add_pipe;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 8-bit, two stages
    logic       d8_in_valid, d8_in_ready, d8_out_valid, d8_out_ready;
    logic [7:0] d8_a, d8_b, d8_x;
    logic       d8_ci, d8_sub, d8_co, d8_ovf;
    // 8-bit, single stage
    logic       d1_in_valid, d1_in_ready, d1_out_valid, d1_out_ready;
    logic [7:0] d1_a, d1_b, d1_x;
    logic       d1_ci, d1_sub, d1_co, d1_ovf;
    // 32-bit, four stages
    logic        d32_in_valid, d32_in_ready, d32_out_valid, d32_out_ready;
    logic [31:0] d32_a, d32_b, d32_x;
    logic        d32_ci, d32_sub, d32_co, d32_ovf;

    add_pipe #(.WIDTH(8), .CHUNK(4)) u_d8 (
        .clk(clk), .rst_n(rst_n), .in_valid(d8_in_valid), .in_ready(d8_in_ready),
        .a(d8_a), .b(d8_b), .ci(d8_ci), .sub(d8_sub), .out_valid(d8_out_valid),
        .out_ready(d8_out_ready), .x(d8_x), .co(d8_co), .ovf(d8_ovf));

    add_pipe #(.WIDTH(8), .CHUNK(8)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(d1_in_valid), .in_ready(d1_in_ready),
        .a(d1_a), .b(d1_b), .ci(d1_ci), .sub(d1_sub), .out_valid(d1_out_valid),
        .out_ready(d1_out_ready), .x(d1_x), .co(d1_co), .ovf(d1_ovf));

    add_pipe #(.WIDTH(32), .CHUNK(8)) u_d32 (
        .clk(clk), .rst_n(rst_n), .in_valid(d32_in_valid), .in_ready(d32_in_ready),
        .a(d32_a), .b(d32_b), .ci(d32_ci), .sub(d32_sub), .out_valid(d32_out_valid),
        .out_ready(d32_out_ready), .x(d32_x), .co(d32_co), .ovf(d32_ovf));

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic       sub;
        logic [7:0] x;
        logic       co;
        logic       ovf;
    } vec_t;

    typedef struct {
        logic [31:0] x;
        logic        co;
        logic        ovf;
    } res32_t;

    localparam int NV = 12;
    vec_t   vecs[NV];
    res32_t q32[$];

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic drive8(input logic v, input logic [7:0] a, input logic [7:0] b,
                          input logic ci, input logic sub);
        d8_in_valid = v;
        d8_a        = a;
        d8_b        = b;
        d8_ci       = ci;
        d8_sub      = sub;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic, independent of the b'/c0 mapping.
    function automatic res32_t model32(input logic [31:0] a, input logic [31:0] b,
                                       input logic ci, input logic sub);
        res32_t      r;
        logic [32:0] w;
        longint      sr;
        if (!sub) begin
            w    = {1'b0, a} + {1'b0, b} + {32'd0, ci};
            r.x  = w[31:0];
            r.co = w[32];
            sr   = longint'($signed(a)) + longint'($signed(b)) + longint'(ci);
        end else begin
            r.x  = a - b - {31'd0, ci};
            r.co = ({1'b0, a} >= ({1'b0, b} + {32'd0, ci}));
            sr   = longint'($signed(a)) - longint'($signed(b)) - longint'(ci);
        end
        r.ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        return r;
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        res32_t exp32;
        int sent, recv, cyc;
        logic       prev_stall;
        logic [7:0] prev_x;

        //          a      b      ci    sub   x      co    ovf
        vecs[0]  = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[1]  = '{8'h01, 8'h01, 1'b1, 1'b0, 8'h03, 1'b0, 1'b0};
        vecs[2]  = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[3]  = '{8'h0F, 8'hF0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[4]  = '{8'h05, 8'h03, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0};
        vecs[5]  = '{8'h03, 8'h05, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[6]  = '{8'h05, 8'h04, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[7]  = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[8]  = '{8'h80, 8'hFF, 1'b0, 1'b0, 8'h7F, 1'b1, 1'b1};
        vecs[9]  = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[10] = '{8'h40, 8'h20, 1'b0, 1'b0, 8'h60, 1'b0, 1'b0};
        vecs[11] = '{8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};

        rst_n = 1'b0;
        drive8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        d8_out_ready  = 1'b1;
        d1_in_valid   = 1'b0; d1_a = '0; d1_b = '0; d1_ci = 1'b0; d1_sub = 1'b0;
        d1_out_ready  = 1'b1;
        d32_in_valid  = 1'b0; d32_a = '0; d32_b = '0; d32_ci = 1'b0; d32_sub = 1'b0;
        d32_out_ready = 1'b1;

        // Reset state
        step();
        step();
        check("reset out_valid", d8_out_valid, 0);
        check("reset x", d8_x, 0);
        check("reset co", d8_co, 0);
        check("reset ovf", d8_ovf, 0);
        check("reset in_ready", d8_in_ready, 1);
        check("reset d32 out_valid", d32_out_valid, 0);
        rst_n = 1'b1;

        // Back-to-back directed table: result of vector s appears after edge s+1.
        for (int s = 0; s <= NV; s++) begin
            if (s < NV) drive8(1'b1, vecs[s].a, vecs[s].b, vecs[s].ci, vecs[s].sub);
            else        drive8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
            step();
            if (s == 0) begin
                check("vec0 not yet valid", d8_out_valid, 0);
            end else begin
                check($sformatf("vec%0d out_valid", s-1), d8_out_valid, 1);
                check($sformatf("vec%0d x", s-1), d8_x, vecs[s-1].x);
                check($sformatf("vec%0d co", s-1), d8_co, vecs[s-1].co);
                check($sformatf("vec%0d ovf", s-1), d8_ovf, vecs[s-1].ovf);
            end
        end
        step();
        check("table drained", d8_out_valid, 0);

        // Backpressure: 6 beats a=10+i, b=01 -> x=11+i, out_ready low on cycles 3..5.
        sent = 0; recv = 0; prev_stall = 1'b0; prev_x = '0;
        for (int c = 0; c < 30 && recv < 6; c++) begin
            drive8(sent < 6, 8'h10 + 8'(sent), 8'h01, 1'b0, 1'b0);
            d8_out_ready = !(c >= 3 && c <= 5);
            #1;
            check($sformatf("bp c%0d in_ready", c), d8_in_ready, !(d8_out_valid && !d8_out_ready));
            if (prev_stall) begin
                check($sformatf("bp c%0d held valid", c), d8_out_valid, 1);
                check($sformatf("bp c%0d held x", c), d8_x, prev_x);
            end
            if (d8_out_valid && d8_out_ready) begin
                check($sformatf("bp beat%0d x", recv), d8_x, 8'h11 + 8'(recv));
                recv++;
            end
            if (d8_in_valid && d8_in_ready) sent++;
            prev_stall = d8_out_valid && !d8_out_ready;
            prev_x     = d8_x;
            step();
        end
        check("bp beats received", recv, 6);
        drive8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        d8_out_ready = 1'b1;
        step();
        step();

        // Reset with two beats in flight (neither retired).
        d8_out_ready = 1'b0;
        drive8(1'b1, 8'h11, 8'h22, 1'b0, 1'b0);
        step();
        drive8(1'b1, 8'h33, 8'h44, 1'b0, 1'b0);
        step();
        check("pre-reset out_valid", d8_out_valid, 1);
        drive8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("mid-reset out_valid", d8_out_valid, 0);
        check("mid-reset x", d8_x, 0);
        check("mid-reset co", d8_co, 0);
        d8_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("flushed beat absent %0d", i), d8_out_valid, 0);
        end
        drive8(1'b1, 8'h02, 8'h03, 1'b0, 1'b0);
        step();
        drive8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        check("post-reset latency", d8_out_valid, 0);
        step();
        check("post-reset out_valid", d8_out_valid, 1);
        check("post-reset x", d8_x, 8'h05);

        // N=1: result visible right after the accept edge.
        d1_in_valid = 1'b1; d1_a = 8'h12; d1_b = 8'h34;
        step();
        check("n1 out_valid", d1_out_valid, 1);
        check("n1 x", d1_x, 8'h46);
        d1_a = 8'h10; d1_b = 8'h20; d1_sub = 1'b1;
        step();
        check("n1 sub x", d1_x, 8'hF0);
        check("n1 sub co", d1_co, 0);
        d1_in_valid = 1'b0;
        step();
        check("n1 idle", d1_out_valid, 0);

        // 32-bit: carry through all four stages, latency 4 edges.
        d32_in_valid = 1'b1; d32_a = 32'hFFFF_FFFF; d32_b = 32'h0000_0001;
        step();
        d32_in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("w32 latency edge %0d", i), d32_out_valid, 0);
            step();
        end
        check("w32 carry valid", d32_out_valid, 1);
        check("w32 carry x", d32_x, 32'h0);
        check("w32 carry co", d32_co, 1);
        check("w32 carry ovf", d32_ovf, 0);

        d32_in_valid = 1'b1; d32_a = 32'h7FFF_FFFF; d32_b = 32'h0000_0001;
        step();
        d32_in_valid = 1'b0;
        repeat (3) step();
        check("w32 ovf valid", d32_out_valid, 1);
        check("w32 ovf x", d32_x, 32'h8000_0000);
        check("w32 ovf flag", d32_ovf, 1);
        check("w32 ovf co", d32_co, 0);
        step();

        // 32-bit random stream with random bubbles and backpressure, scoreboarded.
        sent = 0; recv = 0; cyc = 0;
        while ((sent < 200 || q32.size() != 0) && cyc < 3000) begin
            d32_in_valid = (sent < 200) && ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       d32_a = 32'h7FFF_FFFF;
                1:       d32_a = 32'h8000_0000;
                default: d32_a = $urandom;
            endcase
            d32_b         = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : $urandom;
            d32_ci        = 1'($urandom_range(0, 1));
            d32_sub       = 1'($urandom_range(0, 1));
            d32_out_ready = ($urandom_range(0, 3) != 0);
            #1;
            check("w32 in_ready", d32_in_ready, !(d32_out_valid && !d32_out_ready));
            if (d32_out_valid && d32_out_ready) begin
                if (q32.size() == 0) begin
                    check("w32 unexpected beat", q32.size(), 1);
                end else begin
                    exp32 = q32.pop_front();
                    check($sformatf("w32 beat%0d x", recv), d32_x, exp32.x);
                    check($sformatf("w32 beat%0d co", recv), d32_co, exp32.co);
                    check($sformatf("w32 beat%0d ovf", recv), d32_ovf, exp32.ovf);
                    recv++;
                end
            end
            if (d32_in_valid && d32_in_ready) begin
                q32.push_back(model32(d32_a, d32_b, d32_ci, d32_sub));
                sent++;
            end
            step();
            cyc++;
        end
        check("w32 stream drained", q32.size(), 0);
        check("w32 beats received", recv, 200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
